// File: rtl/ysyx_23060203_pkg.sv
// Shared types and defaults for the flush controller slice.
package ysyx_23060203_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_ICINV = 3'd2,
    S_REDIR = 3'd3,
    S_HOLD  = 3'd4
  } flush_state_t;

  localparam int CNT_W_DEF     = 32;
  localparam int KILL_HOLD_DEF = 1;
endpackage

// File: rtl/ysyx_23060203_sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module ysyx_23060203_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset)
      r_cnt <= '0;
    else if (i_inc && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/ysyx_23060203_flush_ctrl.sv
// Pipeline recovery sequencer: kill younger work, drain LSU / invalidate I$ for fence.i,
// then hand the redirect PC to the IFU over valid/ready.
module ysyx_23060203_flush_ctrl
  import ysyx_23060203_pkg::*;
#(
  parameter int KILL_HOLD = KILL_HOLD_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_flush,
  input  logic [31:0]      wb_dnpc,
  input  logic             wb_fencei,
  output logic             pipe_kill,
  input  logic             lsu_idle,
  output logic             icache_inv_req,
  input  logic             icache_inv_ack,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             busy,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fencei_cnt
);
  localparam int HW = (KILL_HOLD > 1) ? $clog2(KILL_HOLD + 1) : 1;

  flush_state_t r_state;
  logic [31:0]  r_redir_pc;
  logic         r_inv_req;
  logic         r_redir_valid;
  logic [HW-1:0] r_hold;
  logic         w_start;

  assign w_start = (r_state == S_IDLE) && wb_flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_redir_pc    <= '0;
      r_inv_req     <= 1'b0;
      r_redir_valid <= 1'b0;
      r_hold        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (wb_flush) begin
          r_redir_pc    <= wb_dnpc;
          r_state       <= wb_fencei ? S_DRAIN : S_REDIR;
          r_redir_valid <= !wb_fencei;
        end
        S_DRAIN: if (lsu_idle) begin
          r_state   <= S_ICINV;
          r_inv_req <= 1'b1;
        end
        S_ICINV: if (icache_inv_ack) begin
          r_state       <= S_REDIR;
          r_inv_req     <= 1'b0;
          r_redir_valid <= 1'b1;
        end
        S_REDIR: if (redir_ready) begin
          r_redir_valid <= 1'b0;
          if (KILL_HOLD > 0) begin
            r_state <= S_HOLD;
            r_hold  <= HW'(KILL_HOLD);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          // Keeps the kill asserted a few cycles past the redirect so stale fetches die.
          if (r_hold == HW'(1)) r_state <= S_IDLE;
          r_hold <= r_hold - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pipe_kill      = w_start || (r_state != S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign icache_inv_req = r_inv_req;
  assign redir_valid    = r_redir_valid;
  assign redir_pc       = r_redir_pc;

  ysyx_23060203_sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .i_inc (w_start),
    .o_cnt (flush_cnt)
  );

  ysyx_23060203_sat_cnt #(.WIDTH(CNT_W)) u_fencei_cnt (
    .clock (clock),
    .reset (reset),
    .i_inc (w_start && wb_fencei),
    .o_cnt (fencei_cnt)
  );

  // A retiring flush while busy should be impossible since pipe_kill blocks issue.
  a_no_flush_busy: assert property (@(posedge clock) disable iff (reset) !(wb_flush && busy));
endmodule

// File: tb/tb_ysyx_23060203_flush_ctrl.sv
// Directed bench: DUT a (KILL_HOLD=1, CNT_W=32) and DUT b (KILL_HOLD=0, CNT_W=2).
module tb_ysyx_23060203_flush_ctrl;
  logic clock, reset;
  int passed = 0, total = 0, acc_a = 0;

  logic        a_flush, a_fencei, a_lsu_idle, a_ack, a_ready;
  logic [31:0] a_dnpc;
  logic        a_kill, a_req, a_valid, a_busy;
  logic [31:0] a_pc, a_fcnt, a_icnt;

  logic        b_flush, b_fencei, b_lsu_idle, b_ack, b_ready;
  logic [31:0] b_dnpc;
  logic        b_kill, b_req, b_valid, b_busy;
  logic [31:0] b_pc;
  logic [1:0]  b_fcnt, b_icnt;

  ysyx_23060203_flush_ctrl #(.KILL_HOLD(1), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset), .wb_flush(a_flush), .wb_dnpc(a_dnpc), .wb_fencei(a_fencei),
    .pipe_kill(a_kill), .lsu_idle(a_lsu_idle), .icache_inv_req(a_req), .icache_inv_ack(a_ack),
    .redir_valid(a_valid), .redir_pc(a_pc), .redir_ready(a_ready), .busy(a_busy),
    .flush_cnt(a_fcnt), .fencei_cnt(a_icnt));

  ysyx_23060203_flush_ctrl #(.KILL_HOLD(0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .wb_flush(b_flush), .wb_dnpc(b_dnpc), .wb_fencei(b_fencei),
    .pipe_kill(b_kill), .lsu_idle(b_lsu_idle), .icache_inv_req(b_req), .icache_inv_ack(b_ack),
    .redir_valid(b_valid), .redir_pc(b_pc), .redir_ready(b_ready), .busy(b_busy),
    .flush_cnt(b_fcnt), .fencei_cnt(b_icnt));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) if (a_valid && a_ready) acc_a++;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    int acc0;
    reset = 1'b1;
    a_flush = 0; a_fencei = 0; a_lsu_idle = 1; a_ack = 0; a_ready = 1; a_dnpc = '0;
    b_flush = 0; b_fencei = 0; b_lsu_idle = 1; b_ack = 0; b_ready = 1; b_dnpc = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_kill", 32'(a_kill), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_req", 32'(a_req), 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_fcnt", a_fcnt, 0);
    chk("rst_icnt", a_icnt, 0);

    // CSR-write flush, KILL_HOLD=1
    a_flush = 1; a_dnpc = 32'h8000_0104; a_fencei = 0; a_ready = 1;
    #1 chk("csr_kill_T", 32'(a_kill), 1);
    tick(); a_flush = 0;
    chk("csr_valid_T1", 32'(a_valid), 1);
    chk("csr_pc_T1", a_pc, 32'h8000_0104);
    chk("csr_fcnt", a_fcnt, 1);
    tick();
    chk("csr_valid_T2", 32'(a_valid), 0);
    chk("csr_kill_T2", 32'(a_kill), 1);
    chk("csr_busy_T2", 32'(a_busy), 1);
    tick();
    chk("csr_idle_T3", 32'(a_busy), 0);
    chk("csr_kill_T3", 32'(a_kill), 0);
    chk("csr_icnt", a_icnt, 0);
    chk("csr_pc_held", a_pc, 32'h8000_0104);

    // ack outside ICINV is ignored
    a_ack = 1; tick(); a_ack = 0;
    chk("stray_ack_busy", 32'(a_busy), 0);
    chk("stray_ack_req", 32'(a_req), 0);

    // fence.i with LSU busy for 5 cycles, ack 3 cycles after req
    a_flush = 1; a_fencei = 1; a_dnpc = 32'h8000_0200; a_lsu_idle = 0;
    tick(); a_flush = 0; a_fencei = 0;
    for (int i = 0; i < 5; i++) begin
      chk("fi_drain_req", 32'(a_req), 0);
      chk("fi_drain_kill", 32'(a_kill), 1);
      chk("fi_drain_valid", 32'(a_valid), 0);
      tick();
    end
    chk("fi_drain_req_last", 32'(a_req), 0);
    a_lsu_idle = 1;
    tick();
    chk("fi_req_rise", 32'(a_req), 1);
    tick();
    chk("fi_req_hold1", 32'(a_req), 1);
    chk("fi_kill_inv", 32'(a_kill), 1);
    tick();
    chk("fi_req_hold2", 32'(a_req), 1);
    chk("fi_valid_inv", 32'(a_valid), 0);
    a_ack = 1;
    tick(); a_ack = 0;
    chk("fi_req_drop", 32'(a_req), 0);
    chk("fi_valid", 32'(a_valid), 1);
    chk("fi_pc", a_pc, 32'h8000_0200);
    chk("fi_icnt", a_icnt, 1);
    chk("fi_fcnt", a_fcnt, 2);
    tick();
    chk("fi_hold_kill", 32'(a_kill), 1);
    tick();
    chk("fi_idle", 32'(a_busy), 0);

    // Redirect backpressure
    a_ready = 0; acc0 = acc_a;
    a_flush = 1; a_dnpc = 32'h8000_0300;
    tick(); a_flush = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(a_valid), 1);
      chk("bp_pc", a_pc, 32'h8000_0300);
      tick();
    end
    chk("bp_valid_5th", 32'(a_valid), 1);
    a_ready = 1;
    tick();
    chk("bp_valid_drop", 32'(a_valid), 0);
    chk("bp_hold_busy", 32'(a_busy), 1);
    tick();
    chk("bp_idle", 32'(a_busy), 0);
    chk("bp_single_accept", 32'(acc_a - acc0), 1);

    // Reset while in ICINV
    a_flush = 1; a_fencei = 1; a_dnpc = 32'h8000_0400; a_lsu_idle = 1;
    tick(); a_flush = 0; a_fencei = 0;
    tick();
    chk("rinv_req", 32'(a_req), 1);
    reset = 1;
    tick(); reset = 0;
    chk("rinv_busy", 32'(a_busy), 0);
    chk("rinv_req0", 32'(a_req), 0);
    chk("rinv_kill", 32'(a_kill), 0);
    chk("rinv_valid", 32'(a_valid), 0);
    chk("rinv_fcnt", a_fcnt, 0);
    chk("rinv_icnt", a_icnt, 0);

    // KILL_HOLD=0, CNT_W=2: back-to-back flushes, counter saturates at 3
    b_ready = 1;
    for (int i = 0; i < 5; i++) begin
      b_flush = 1; b_dnpc = 32'h8000_1000 + 32'(i * 4);
      #1 chk("b_kill_T", 32'(b_kill), 1);
      tick(); b_flush = 0;
      chk("b_valid", 32'(b_valid), 1);
      chk("b_pc", b_pc, 32'h8000_1000 + 32'(i * 4));
      chk("b_fcnt", 32'(b_fcnt), (i < 3) ? i + 1 : 3);
      tick();
      chk("b_idle", 32'(b_busy), 0);
      chk("b_kill_idle", 32'(b_kill), 0);
    end
    chk("b_icnt", 32'(b_icnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
